// File: rtl/board_ctl.sv
// board_ctl: GRID_N x GRID_N board controller for the two-player grid game.
// Maps mouse clicks to cells, tracks occupancy/owner per cell, enforces turn
// order, ships local moves to the UART via valid/ready and applies remote
// moves. Optional line detection is built when BOARD_CTL_WIN_DETECT_EN is
// defined (adds the win/winner outputs).
module board_ctl #(
    parameter int GRID_N  = 3,
    parameter int PITCH_X = 342,
    parameter int CELL_W  = 339,
    parameter int PITCH_Y = 256,
    parameter int CELL_H  = 252
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic [11:0]                xpos,
    input  logic [11:0]                ypos,
    input  logic                       mouse_left,
    input  logic                       start_en,
    input  logic                       choice_en,
    input  logic                       player_id,
    input  logic                       new_game,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    input  logic                       tx_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    output logic [GRID_N*GRID_N-1:0]   occupied,
    output logic [GRID_N*GRID_N-1:0]   owner,
    output logic                       turn,
    output logic [6:0]                 move_cnt,
    output logic                       board_full,
    output logic                       rx_err
`ifdef BOARD_CTL_WIN_DETECT_EN
    ,
    output logic                       win,
    output logic                       winner
`endif
);

    localparam int NCELL = GRID_N * GRID_N;

    typedef enum logic [1:0] {IDLE, PLAY, TX, DONE} state_t;

    state_t             state_q;
    logic               mouse_prev_q;
    logic [NCELL-1:0]   occupied_q;
    logic [NCELL-1:0]   owner_q;
    logic               turn_q;
    logic [6:0]         move_cnt_q;
    logic               board_full_q;
    logic               tx_valid_q;
    logic [7:0]         tx_data_q;
    logic               rx_err_q;

    logic               play_en;
    logic               click;
    logic               col_hit, row_hit;
    logic [2:0]         col_sel, row_sel;
    logic [5:0]         click_idx, rx_idx;
    logic [NCELL-1:0]   click_mask, rx_mask;
    logic               local_free, rx_legal;
    logic [6:0]         cnt_inc;
    logic               last_move;
    logic               local_commit, remote_commit, rx_reject;
    logic               win_now;

    assign play_en = start_en & ~choice_en;
    assign click   = mouse_left & ~mouse_prev_q;

    // Hit test: locate the column/row whose clickable window contains the pointer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        col_hit = 1'b0;
        col_sel = '0;
        row_hit = 1'b0;
        row_sel = '0;
        for (int c = 0; c < GRID_N; c++) begin
            if (int'(xpos) >= c * PITCH_X && int'(xpos) < c * PITCH_X + CELL_W) begin
                col_hit = 1'b1;
                col_sel = 3'(c);
            end
        end
        for (int r = 0; r < GRID_N; r++) begin
            if (int'(ypos) >= r * PITCH_Y && int'(ypos) < r * PITCH_Y + CELL_H) begin
                row_hit = 1'b1;
                row_sel = 3'(r);
            end
        end
    end

    assign click_idx  = 6'(int'(row_sel) * GRID_N + int'(col_sel));
    assign click_mask = {{(NCELL-1){1'b0}}, 1'b1} << click_idx;
    assign local_free = col_hit & row_hit & ~|(occupied_q & click_mask);

    assign rx_idx     = rx_data[5:0];
    assign rx_mask    = {{(NCELL-1){1'b0}}, 1'b1} << rx_idx;
    assign rx_legal   = (rx_data[7:6] == 2'b01) && (int'(rx_idx) < NCELL)
                        && ~|(occupied_q & rx_mask);

    assign cnt_inc    = move_cnt_q + 7'd1;
    assign last_move  = (cnt_inc == 7'(NCELL));

    // A move is only taken in PLAY, with play enabled, no pending line, from the source whose turn it is.
    assign local_commit  = ~new_game & (state_q == PLAY) & ~win_now & play_en
                           & (turn_q == player_id) & click & local_free;
    assign remote_commit = ~new_game & (state_q == PLAY) & ~win_now & play_en
                           & (turn_q != player_id) & rx_valid & rx_legal;
    assign rx_reject     = ~new_game & rx_valid & ~remote_commit & (state_q != DONE)
                           & ~((state_q == PLAY) & win_now);

    // Main controller: board state, turn, UART handshake and game phase.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mouse_prev_q <= 1'b0;
            occupied_q   <= '0;
            owner_q      <= '0;
            turn_q       <= 1'b0;
            move_cnt_q   <= '0;
            board_full_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            rx_err_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            mouse_prev_q <= mouse_left;
            rx_err_q     <= rx_reject;
            if (new_game) begin
                state_q      <= IDLE;
                occupied_q   <= '0;
                owner_q      <= '0;
                turn_q       <= 1'b0;
                move_cnt_q   <= '0;
                board_full_q <= 1'b0;
                tx_valid_q   <= 1'b0;
                tx_data_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (play_en) state_q <= PLAY;
                    end
                    PLAY: begin
                        if (win_now) begin
                            state_q <= DONE;
                        end else if (!play_en) begin
                            state_q <= IDLE;
                        end else if (local_commit) begin
                            occupied_q   <= occupied_q | click_mask;
                            owner_q      <= player_id ? (owner_q | click_mask) : (owner_q & ~click_mask);
                            move_cnt_q   <= cnt_inc;
                            board_full_q <= last_move;
                            tx_data_q    <= {2'b01, click_idx};
                            tx_valid_q   <= 1'b1;
                            state_q      <= TX;
                        end else if (remote_commit) begin
                            occupied_q   <= occupied_q | rx_mask;
                            owner_q      <= player_id ? (owner_q & ~rx_mask) : (owner_q | rx_mask);
                            move_cnt_q   <= cnt_inc;
                            board_full_q <= last_move;
                            turn_q       <= ~turn_q;
                            if (last_move) state_q <= DONE;
                        end
                    end
                    TX: begin
                        if (tx_ready) begin
                            tx_valid_q <= 1'b0;
                            turn_q     <= ~turn_q;
                            if (board_full_q || win_now) state_q <= DONE;
                            else if (play_en)             state_q <= PLAY;
                            else                          state_q <= IDLE;
                        end
                    end
                    DONE: ;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef BOARD_CTL_WIN_DETECT_EN
    logic             check_q, mover_q, win_q, winner_q;
    logic             line_hit, all_row, all_col, all_diag, all_anti;
    logic [NCELL-1:0] mine;

    // Line scan over the last mover's cells: any full row, column or diagonal.
    always_comb begin
        mine     = occupied_q & (mover_q ? owner_q : ~owner_q);
        line_hit = 1'b0;
        all_row  = 1'b1;
        all_col  = 1'b1;
        all_diag = 1'b1;
        all_anti = 1'b1;
        for (int i = 0; i < GRID_N; i++) begin
            all_row = 1'b1;
            all_col = 1'b1;
            for (int j = 0; j < GRID_N; j++) begin
                all_row &= mine[i*GRID_N + j];
                all_col &= mine[j*GRID_N + i];
            end
            line_hit |= all_row | all_col;
            all_diag &= mine[i*GRID_N + i];
            all_anti &= mine[i*GRID_N + (GRID_N - 1 - i)];
        end
        line_hit |= all_diag | all_anti;
    end

    assign win_now = win_q | (check_q & line_hit);

    // Arm a check on the cycle after each commit and latch the result.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            check_q  <= 1'b0;
            mover_q  <= 1'b0;
            win_q    <= 1'b0;
            winner_q <= 1'b0;
        end else if (new_game) begin
            check_q  <= 1'b0;
            mover_q  <= 1'b0;
            win_q    <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            check_q <= local_commit | remote_commit;
            if (local_commit)       mover_q <= player_id;
            else if (remote_commit) mover_q <= ~player_id;
            if (check_q && line_hit) begin
                win_q    <= 1'b1;
                winner_q <= mover_q;
            end
        end
    end

    assign win    = win_q;
    assign winner = winner_q;
`else
    assign win_now = 1'b0;
`endif

    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign occupied   = occupied_q;
    assign owner      = owner_q;
    assign turn       = turn_q;
    assign move_cnt   = move_cnt_q;
    assign board_full = board_full_q;
    assign rx_err     = rx_err_q;

endmodule

// File: doc/board_ctl.md
Name: board_ctl

Overview:
- Parametrised N×N board controller for the two-player grid game. Next generation of the fixed 3×3 square controller.
- Maps local mouse clicks to cells and records occupancy and owner per cell.
- Serialises each local move to the UART transmitter with a valid/ready handshake, and accepts moves received from the remote board.
- Enforces turn order, rejects illegal moves, and detects a full board. Sits between the mouse/UART blocks and the board-drawing blocks.

Parameters:
- GRID_N, 3, cells per side; legal range 3..8.
- PITCH_X, 342, horizontal pixel pitch between column origins.
- CELL_W, 339, clickable width of a cell in pixels.
- PITCH_Y, 256, vertical pixel pitch between row origins.
- CELL_H, 252, clickable height of a cell in pixels.

Ports:
- pclk  in  1  pixel clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- xpos  in  12  mouse x.
- ypos  in  12  mouse y.
- mouse_left  in  1  left button level.
- start_en  in  1  game screen active.
- choice_en  in  1  colour-choice screen active; blocks play.
- player_id  in  1  local player; player 0 moves first.
- new_game  in  1  synchronous board clear.
- rx_valid  in  1  one-cycle strobe: rx_data holds a remote move.
- rx_data  in  8  remote move byte.
- tx_ready  in  1  UART transmitter accepts tx_data.
- tx_valid  out  1  local move byte pending.
- tx_data  out  8  local move byte.
- occupied  out  GRID_N*GRID_N  cell taken; bit i = row*GRID_N+col.
- owner  out  GRID_N*GRID_N  owning player per cell; valid only where occupied=1.
- turn  out  1  player allowed to move next.
- move_cnt  out  7  moves committed.
- board_full  out  1  all cells occupied.
- rx_err  out  1  one-cycle pulse: remote byte rejected.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, state IDLE, button history 0.
- Move byte format: {2'b01, idx[5:0]}, with idx = row*GRID_N+col.
- play_en = start_en & ~choice_en.
- new_game has highest priority. When 1: clear occupied, owner, move_cnt, turn, tx_valid, board_full; go to IDLE.
- Click = rising edge of mouse_left (registered previous level). A held button produces exactly one click.
- Cell hit test:
  - col = xpos/PITCH_X, valid when xpos%PITCH_X < CELL_W and col < GRID_N.
  - row computed likewise from ypos, PITCH_Y, CELL_H.
  - Clicks in gaps or beyond the grid are ignored.
  - Division and modulo are realised by comparator chains (no divider).
- States:
  - IDLE: if play_en, go to PLAY.
  - PLAY (turn==player_id): a click on a free cell at cycle t gives, at t+1: occupied[idx]=1, owner[idx]=player_id, move_cnt+1, tx_data=move byte, tx_valid=1; go to TX. Clicks on occupied cells are ignored.
  - PLAY (turn!=player_id): clicks are ignored.
  - TX: hold tx_valid and tx_data stable until a cycle with tx_ready=1. The next cycle: tx_valid=0, turn toggles, go to PLAY or DONE. Clicks are ignored while in TX.
  - DONE: entered when board_full is set. All clicks and rx are ignored until new_game.
- Remote move: accepted only in PLAY with turn!=player_id, a valid prefix, idx<GRID_N², and the cell free. At t+1: occupied[idx]=1, owner[idx]=~player_id, move_cnt+1, turn toggles. Otherwise rx_err pulses at t+1 and the board is unchanged.
- Click and rx_valid in the same cycle: only the source matching turn is considered. An rx in the wrong turn raises rx_err.
- Falling play_en: returns to IDLE with the board kept. A pending TX completes first.
- board_full = (move_cnt == GRID_N²), registered alongside the final commit.

Optional Feature:
- Macro: BOARD_CTL_WIN_DETECT_EN.
- When defined, adds outputs win (1 bit) and winner (1 bit).
- After each commit, the last mover's cells are checked for a complete row, column, main diagonal or anti-diagonal of length GRID_N.
- On a match: win=1 and winner=mover, one cycle after the commit; go to DONE after TX completes.
- win and winner are cleared by reset or new_game.
- When undefined: no win ports or logic; DONE is reached only via board_full.

Test Plan:
- GRID_N=3, player_id=0, play_en=1, click at (400,300) → t+1: occupied=9'h010, owner[4]=0, tx_data=8'h44, tx_valid held through 3 cycles of tx_ready=0, drops the cycle after tx_ready=1, turn=1.
- turn=1, rx_valid with rx_data=8'h40 → occupied[0]=1, owner[0]=1, turn=0, rx_err=0; repeat the same byte → rx_err pulse, board unchanged.
- Click in gap x=340, or click on an occupied cell, or mouse_left held high for 10 cycles → at most one commit; gap and occupied clicks produce none.
- Nine alternating legal moves with no line → board_full=1, move_cnt=9, later clicks and rx ignored; new_game → all cleared, turn=0.
- rst_n asserted while in TX mid-handshake → tx_valid=0 and all outputs 0 immediately, without waiting for a clock edge.
- With BOARD_CTL_WIN_DETECT_EN and GRID_N=4: player 0 fills cells 0, 5, 10, 15 → win=1, winner=0 one cycle after the fourth commit; then DONE.
